fpm_accumulator: RTL and testbench

- Downstream stage of multiplierfpm. Consumes FP32 products and keeps a running IEEE-754 single-precision sum (acc += product).
- Multi-cycle FSM datapath: unpack/align, add, normalize, round. Fixed latency.
- Valid/ready handshake on the input side. One-cycle done pulse on the output side.
- Forms the accumulate half of the processor's FP multiply-accumulate path.

---
 rtl/fpm_accumulator_if.sv | 31 +++
 rtl/fpm_accumulator.sv | 233 +++++++++++++++++++++++
 tb/tb_fpm_accumulator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpm_accumulator_if.sv
// Product input handshake and accumulator result bundle for fpm_accumulator.
// Optional flags[2:0] = {nan, overflow, inexact} when FPACC_FLAGS_EN is defined.
interface fpm_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] acc_out;
    logic        out_valid;
    logic        busy;
`ifdef FPACC_FLAGS_EN
    logic [2:0]  flags;

    modport master (
        output in_valid, in_data,
        input  in_ready, acc_out, out_valid, busy, flags
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, acc_out, out_valid, busy, flags
    );
`else
    modport master (
        output in_valid, in_data,
        input  in_ready, acc_out, out_valid, busy
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, acc_out, out_valid, busy
    );
`endif
endinterface

// File: rtl/fpm_accumulator.sv
// FP32 running-sum accumulator: IDLE -> ALIGN -> ADD -> NORM -> ROUND, 4-cycle ops.
// Define FPACC_FLAGS_EN to add sticky {nan, overflow, inexact} flags.
module fpm_accumulator #(
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    fpm_accumulator_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] acc_q;
    logic [31:0] prod_q;
    logic        out_valid_q;
    logic        spec_q;
    logic [31:0] sval_q;
    logic        sign_q;
    logic        sub_q;
    logic [9:0]  exp_q;
    logic [26:0] ma_q;
    logic [26:0] mb_q;
    logic [27:0] sum_q;
    logic [26:0] nm_q;
    logic        zero_q;

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.in_valid) state_nx = ALIGN;
                ALIGN:   state_nx = ADD;
                ADD:     state_nx = NORM;
                NORM:    state_nx = ROUND;
                ROUND:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Special operands bypass the datapath but still ride the pipeline.
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        spec_c;
    logic [31:0] sval_c;

    always_comb begin
        a_nan  = (&acc_q[30:23]) && (|acc_q[22:0]);
        b_nan  = (&prod_q[30:23]) && (|prod_q[22:0]);
        a_inf  = (&acc_q[30:23]) && !(|acc_q[22:0]);
        b_inf  = (&prod_q[30:23]) && !(|prod_q[22:0]);
        a_zero = (acc_q[30:23] == 8'd0);
        b_zero = (prod_q[30:23] == 8'd0);
        spec_c = 1'b1;
        sval_c = 32'h7FC0_0000;
        if (a_nan || b_nan) begin
            sval_c = 32'h7FC0_0000;
        end else if (a_inf && b_inf && (acc_q[31] ^ prod_q[31])) begin
            sval_c = 32'h7FC0_0000;
        end else if (a_inf) begin
            sval_c = acc_q;
        end else if (b_inf) begin
            sval_c = prod_q;
        end else if (a_zero && b_zero) begin
            sval_c = {acc_q[31] & prod_q[31], 31'd0};
        end else if (a_zero) begin
            sval_c = prod_q;
        end else if (b_zero) begin
            sval_c = acc_q;
        end else begin
            spec_c = 1'b0;
        end
    end

    logic        a_big;
    logic [31:0] big;
    logic [30:0] sml;
    logic [7:0]  dexp;
    logic [26:0] m_big, m_sml, m_sh;

    always_comb begin
        a_big = (acc_q[30:0] >= prod_q[30:0]);
        big   = a_big ? acc_q : prod_q;
        sml   = a_big ? prod_q[30:0] : acc_q[30:0];
        dexp  = big[30:23] - sml[30:23];
        m_big = {1'b1, big[22:0], 3'b000};
        m_sml = {1'b1, sml[22:0], 3'b000};
        if (dexp >= 8'd27) begin
            m_sh = 27'd1;
        end else begin
            m_sh = (m_sml >> dexp)
                 | {26'd0, |(m_sml & ~(27'h7FF_FFFF << dexp))};
        end
    end

    logic [27:0] sum_c;
    assign sum_c = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                         : ({1'b0, ma_q} + {1'b0, mb_q});

    logic [4:0]  lz;
    logic        found;
    logic [26:0] nm_c;
    logic [9:0]  ne_c;
    logic        nz_c;

    always_comb begin
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum_q[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        nm_c = sum_q[26:0];
        ne_c = exp_q;
        nz_c = 1'b0;
        if (sum_q[27]) begin
            nm_c = {sum_q[27:2], sum_q[1] | sum_q[0]};
            ne_c = exp_q + 10'd1;
        end else if (sum_q[26:0] == 27'd0) begin
            nz_c = 1'b1;
        end else begin
            nm_c = sum_q[26:0] << lz;
            ne_c = exp_q - {5'd0, lz};
            if (ne_c[9] || ne_c == 10'd0) nz_c = 1'b1;
        end
    end

    logic        rnd_up;
    logic [24:0] mr;
    logic [9:0]  re;
    logic [22:0] frac;
    logic        ovf;
    logic [31:0] res_c;

    always_comb begin
        rnd_up = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
        mr     = {1'b0, nm_q[26:3]} + {24'd0, rnd_up};
        re     = exp_q + {9'd0, mr[24]};
        frac   = mr[24] ? mr[23:1] : mr[22:0];
        ovf    = (re >= 10'd255);
        if (spec_q)      res_c = sval_q;
        else if (zero_q) res_c = 32'h0000_0000;
        else if (ovf)    res_c = {sign_q, 8'hFF, 23'd0};
        else             res_c = {sign_q, re[7:0], frac};
    end

`ifdef FPACC_FLAGS_EN
    logic [2:0] flags_q;
    assign bus.flags = flags_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= ACC_INIT;
            prod_q      <= 32'd0;
            out_valid_q <= 1'b0;
            spec_q      <= 1'b0;
            sval_q      <= 32'd0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            exp_q       <= 10'd0;
            ma_q        <= 27'd0;
            mb_q        <= 27'd0;
            sum_q       <= 28'd0;
            nm_q        <= 27'd0;
            zero_q      <= 1'b0;
`ifdef FPACC_FLAGS_EN
            flags_q     <= 3'b000;
`endif
        end else if (clr) begin
            acc_q       <= ACC_INIT;
            out_valid_q <= 1'b0;
`ifdef FPACC_FLAGS_EN
            flags_q     <= 3'b000;
`endif
        end else begin
            out_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) prod_q <= bus.in_data;
                end
                ALIGN: begin
                    spec_q <= spec_c;
                    sval_q <= sval_c;
                    sign_q <= big[31];
                    sub_q  <= acc_q[31] ^ prod_q[31];
                    exp_q  <= {2'b00, big[30:23]};
                    ma_q   <= m_big;
                    mb_q   <= m_sh;
                end
                ADD: begin
                    sum_q <= sum_c;
                end
                NORM: begin
                    nm_q   <= nm_c;
                    exp_q  <= ne_c;
                    zero_q <= nz_c;
                end
                ROUND: begin
                    acc_q       <= res_c;
                    out_valid_q <= 1'b1;
`ifdef FPACC_FLAGS_EN
                    flags_q <= flags_q | {
                        spec_q && (sval_q == 32'h7FC0_0000),
                        !spec_q && !zero_q && ovf,
                        !spec_q && !zero_q && (|nm_q[2:0])
                    };
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpm_accumulator.sv
// Self-checking bench for fpm_accumulator: directed vector table, clr/reset
// corner sequences, and randomized sums against an exact-arithmetic model.
module tb_fpm_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    fpm_accumulator_if bus ();

    fpm_accumulator #(.ACC_INIT(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          do_clr;
        logic [31:0] data;
        logic [31:0] expect_acc;
        logic [2:0]  expect_flags;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    // Exact sum of two FP32 values, rounded to nearest-even, FTZ.
    function automatic logic [31:0] fp_ref(input logic [31:0] a,
                                           input logic [31:0] b);
        int     ea, eb, emin, sh, p, e;
        longint va, vb, s, mag, q, rem, half;
        logic   sgn;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
            return 32'h7FC0_0000;
        if (ea == 255 && eb == 255)
            return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (ea - eb > 32) return a;
        if (eb - ea > 32) return b;
        emin = (ea < eb) ? ea : eb;
        va = longint'({1'b1, a[22:0]}) << (ea - emin);
        vb = longint'({1'b1, b[22:0]}) << (eb - emin);
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        s = va + vb;
        if (s == 0) return 32'h0000_0000;
        sgn = (s < 0);
        mag = sgn ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = emin + p - 23;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = mag << (23 - p);
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        if (e < 1) return 32'h0000_0000;
        return {sgn, 8'(e), q[22:0]};
    endfunction

    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_acc", bus.acc_out, 32'h0000_0000);
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] req,
                        input string nm);
        int k;
        bit hs_ok;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20) begin
            tests++;
            fails++;
            $display("FAIL %s_ready_timeout: in_ready stuck low", nm);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        hs_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready || !bus.busy || bus.out_valid) hs_ok = 1'b0;
            bus.in_data  = $urandom;
            bus.in_valid = (i < 3) ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        chk({nm, "_busy"}, {31'd0, hs_ok}, 32'd1);
        chk({nm, "_done"},
            {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd6);
        chk({nm, "_acc"}, bus.acc_out, req);
    endtask

    logic [31:0] model_acc;
    logic [31:0] op;
    bit          seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h3F00_0000, 32'h3F00_0000, 3'b000, "half"};
        vecs[1]  = '{1'b0, 32'h3FE0_0000, 32'h4010_0000, 3'b000, "add225"};
        vecs[2]  = '{1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'b000, "one"};
        vecs[3]  = '{1'b0, 32'hBF80_0000, 32'h0000_0000, 3'b000, "cancel"};
        vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 3'b000, "negzero"};
        vecs[5]  = '{1'b1, 32'h3F80_0000, 32'h3F80_0000, 3'b000, "tie_ld"};
        vecs[6]  = '{1'b0, 32'h3380_0000, 32'h3F80_0000, 3'b001, "tie_dn"};
        vecs[7]  = '{1'b1, 32'h3F80_0001, 32'h3F80_0001, 3'b000, "odd_ld"};
        vecs[8]  = '{1'b0, 32'h3380_0000, 32'h3F80_0002, 3'b001, "tie_up"};
        vecs[9]  = '{1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, "max_ld"};
        vecs[10] = '{1'b0, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010, "ovf"};
        vecs[11] = '{1'b0, 32'hFF80_0000, 32'h7FC0_0000, 3'b110, "inf_inf"};
        vecs[12] = '{1'b0, 32'h3F80_0000, 32'h7FC0_0000, 3'b110, "nan_st"};
        vecs[13] = '{1'b1, 32'hFF80_0000, 32'hFF80_0000, 3'b000, "ninf"};
        vecs[14] = '{1'b0, 32'h4200_0000, 32'hFF80_0000, 3'b000, "inf_fin"};
        vecs[15] = '{1'b1, 32'h0040_0000, 32'h0000_0000, 3'b000, "denorm"};
        vecs[16] = '{1'b0, 32'h4040_0000, 32'h4040_0000, 3'b000, "three"};
        vecs[17] = '{1'b0, 32'h8040_0000, 32'h4040_0000, 3'b000, "ndenorm"};

        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        #12;
        chk("rst_acc", bus.acc_out, 32'h0000_0000);
        chk("rst_ctl", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ctl", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
`ifdef FPACC_FLAGS_EN
        chk("rst_flags", {29'd0, bus.flags}, 32'd0);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].do_clr) clr_pulse();
            send(vecs[i].data, vecs[i].expect_acc, vecs[i].name);
`ifdef FPACC_FLAGS_EN
            chk({vecs[i].name, "_flags"}, {29'd0, bus.flags},
                {29'd0, vecs[i].expect_flags});
`endif
        end

        // clr during NORM discards the in-flight product
        clr_pulse();
        send(32'h3F80_0000, 32'h3F80_0000, "pre_clr");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("midclr_ctl",
            {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
        chk("midclr_acc", bus.acc_out, 32'h0000_0000);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        chk("midclr_quiet", {31'd0, seen}, 32'd0);

        // clr wins over a simultaneous accept
        send(32'h3F80_0000, 32'h3F80_0000, "pre_clr2");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_0000;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clracc_ctl",
            {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
        chk("clracc_acc", bus.acc_out, 32'h0000_0000);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        chk("clracc_quiet", {31'd0, seen}, 32'd0);

        // async reset during ADD
        send(32'h3F80_0000, 32'h3F80_0000, "pre_rst");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_acc", bus.acc_out, 32'h0000_0000);
        chk("arst_ctl", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h3F00_0000, 32'h3F00_0000, "post_rst");

        // randomized sums against the exact model
        clr_pulse();
        model_acc = 32'h0000_0000;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(7, 0) == 0) begin
                clr_pulse();
                model_acc = 32'h0000_0000;
            end
            op = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
            model_acc = fp_ref(model_acc, op);
            send(op, model_acc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
